// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, defaults and state encoding for the FFT peak detector
package fft_pkg;

    localparam int NPT_DEF = 1024;
    localparam int SW      = 16;
    localparam int PW      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/fft_magsq.sv
// rtl/fft_magsq.sv - two-stage RE^2+IM^2 pipeline with valid/index/eop tags carried alongside
module fft_magsq
    import fft_pkg::*;
#(
    parameter int TW = 10
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 in_vld,
    input  logic                 in_eop,
    input  logic [TW-1:0]        in_idx,
    input  logic signed [SW-1:0] in_re,
    input  logic signed [SW-1:0] in_im,
    output logic                 out_vld,
    output logic                 out_eop,
    output logic [TW-1:0]        out_idx,
    output logic [PW-1:0]        out_pow
);

    logic signed [PW-1:0] re_ext;
    logic signed [PW-1:0] im_ext;
    logic [PW-1:0]        sq_re;
    logic [PW-1:0]        sq_im;
    logic                 s1_vld;
    logic                 s1_eop;
    logic [TW-1:0]        s1_idx;

    // Each square is at most 2^30, so the 32-bit sum tops out at 2^31 without wrapping.
    assign re_ext = {{(PW-SW){in_re[SW-1]}}, in_re};
    assign im_ext = {{(PW-SW){in_im[SW-1]}}, in_im};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_vld <= 1'b0;
            s1_eop <= 1'b0;
            s1_idx <= '0;
            sq_re  <= '0;
            sq_im  <= '0;
        end else begin
            s1_vld <= in_vld;
            s1_eop <= in_vld & in_eop;
            s1_idx <= in_idx;
            sq_re  <= $unsigned(re_ext * re_ext);
            sq_im  <= $unsigned(im_ext * im_ext);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            out_vld <= 1'b0;
            out_eop <= 1'b0;
            out_idx <= '0;
            out_pow <= '0;
        end else begin
            out_vld <= s1_vld;
            out_eop <= s1_eop;
            out_idx <= s1_idx;
            out_pow <= sq_re + sq_im;
        end
    end

endmodule

// File: rtl/fft_peak_det.sv
// rtl/fft_peak_det.sv - per-frame peak power bin search over a streamed FFT output
module fft_peak_det
    import fft_pkg::*;
#(
    parameter int NPT    = NPT_DEF,
    parameter int SKIPDC = 1
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     FFTDOV,
    input  logic                     FFTSOP,
    input  logic                     FFTEOP,
    input  logic signed [SW-1:0]     FFTREO,
    input  logic signed [SW-1:0]     FFTIMO,
    output logic                     PKVLD,
    output logic [$clog2(NPT)-1:0]   PKIDX,
    output logic [PW-1:0]            PKMAG,
    output logic                     PKERR,
    output logic                     BUSY
);

    localparam int            IW   = $clog2(NPT);
    localparam logic [IW-1:0] LAST = IW'(NPT - 1);

    state_t        state;
    state_t        state_d;
    logic [IW-1:0] cnt;
    logic [IW-1:0] cnt_d;
    logic          acc_vld;
    logic          acc_eop;
    logic [IW-1:0] acc_idx;
    logic          err_d;
    logic          done;

    logic          s2_vld;
    logic          s2_eop;
    logic [IW-1:0] s2_idx;
    logic [PW-1:0] s2_pow;

    logic [PW-1:0] max_pow;
    logic [IW-1:0] max_idx;
    logic [PW-1:0] nxt_pow;
    logic [IW-1:0] nxt_idx;

    fft_magsq #(
        .TW (IW)
    ) u_magsq (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .in_vld  (acc_vld),
        .in_eop  (acc_eop),
        .in_idx  (acc_idx),
        .in_re   (FFTREO),
        .in_im   (FFTIMO),
        .out_vld (s2_vld),
        .out_eop (s2_eop),
        .out_idx (s2_idx),
        .out_pow (s2_pow)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            cnt   <= '0;
            PKERR <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            PKERR <= err_d;
        end
    end

    // Only well-formed samples enter the power pipeline; only the final in-range EOP is tagged.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        acc_vld = 1'b0;
        acc_eop = 1'b0;
        acc_idx = cnt;
        err_d   = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (FFTDOV && FFTSOP) begin
                    state_d = ST_ACC;
                    cnt_d   = IW'(1);
                    acc_vld = 1'b1;
                    acc_idx = '0;
                end
            end
            ST_ACC: begin
                if (FFTDOV) begin
                    if (FFTSOP) begin
                        cnt_d   = IW'(1);
                        acc_vld = 1'b1;
                        acc_idx = '0;
                    end else if (cnt == LAST) begin
                        cnt_d = '0;
                        if (FFTEOP) begin
                            acc_vld = 1'b1;
                            acc_eop = 1'b1;
                            state_d = ST_FLUSH;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (FFTEOP) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_vld = 1'b1;
                        cnt_d   = cnt + IW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (s2_vld && s2_eop) begin
                    state_d = ST_OUT;
                    done    = 1'b1;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // An index-0 sample reseeds the search, which also discards any partial or aborted frame.
    always_comb begin
        nxt_pow = max_pow;
        nxt_idx = max_idx;
        if (s2_vld) begin
            if (s2_idx == '0) begin
                if (SKIPDC != 0) begin
                    nxt_pow = '0;
                    nxt_idx = IW'(1);
                end else begin
                    nxt_pow = s2_pow;
                    nxt_idx = '0;
                end
            end else if (s2_pow > max_pow) begin
                nxt_pow = s2_pow;
                nxt_idx = s2_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            max_pow <= '0;
            max_idx <= '0;
            PKMAG   <= '0;
            PKIDX   <= '0;
        end else begin
            max_pow <= nxt_pow;
            max_idx <= nxt_idx;
            if (done) begin
                PKMAG <= nxt_pow;
                PKIDX <= nxt_idx;
            end
        end
    end

    assign PKVLD = (state == ST_OUT);
    assign BUSY  = (state == ST_ACC) || (state == ST_FLUSH);

endmodule
